seven_seg_scan: RTL and testbench

Time-multiplexed driver for a common-anode multi-digit seven-segment display. It sits directly downstream of the free-running refresh counter and consumes its one-cycle `tick` as the digit-advance strobe. Each tick it rotates the active anode, decodes the selected hex nibble to segments, and inserts a one-clock ghosting blank. New display values are applied only at frame boundaries, so a multi-digit value never tears mid-scan.

---
 rtl/seven_seg_scan.sv | 217 +++++++++++++++++++++
 tb/tb_seven_seg_scan.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan.sv
// -----------------------------------------------------------------------------
// seven_seg_scan
//
// Time-multiplexed driver for a common-anode multi-digit seven-segment
// display. Each scan_tick rotates the active anode through a one-clock
// ghosting blank, decodes the selected hex nibble to active-low segments and
// optionally suppresses leading zeros. New display data is double-buffered
// (shadow -> disp) and only transferred at the frame wrap, so a multi-digit
// value never tears mid-scan.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous reset, active-low
//   scan_tick  one-cycle digit-advance strobe from the refresh counter
//   enable     1 = scanning, 0 = all anodes off (pending load applied at once)
//   load       one-cycle request to capture value/dp_in
//   value      4*DIGITS hex nibbles, nibble i -> digit i (digit 0 rightmost)
//   dp_in      decimal point per digit, 1 = lit
//   blank_lz   1 = suppress leading zeros (digit 0 never blanked)
//   load_ack   one-cycle pulse on the clock the shadow is applied to disp
//   an         anode enables, active-low, one-hot-low while showing
//   seg        segments a..g on seg[0]..seg[6], active-low
//   dp         decimal point, active-low
// All outputs are registered.
// -----------------------------------------------------------------------------
module seven_seg_scan #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  scan_tick,
    input  logic                  enable,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  blank_lz,
    output logic                  load_ack,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  dp
);

    localparam int               IDX_W    = $clog2(DIGITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    typedef enum logic {
        SHOW  = 1'b0,
        BLANK = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    state_t                state_reg,     state_next;
    logic [IDX_W-1:0]      idx_reg,       idx_next;
    logic [4*DIGITS-1:0]   shadow_reg;
    logic [DIGITS-1:0]     shadow_dp_reg;
    logic                  pending_reg;
    logic [4*DIGITS-1:0]   disp_reg;
    logic [DIGITS-1:0]     disp_dp_reg;
    logic [DIGITS-1:0]     an_reg,        an_next;
    logic [6:0]            seg_reg,       seg_next;
    logic                  dp_reg,        dp_next;
    logic                  load_ack_reg;

    // -------------------------------------------------------------------------
    // Hex to active-low segment decode, bit order g..a
    // -------------------------------------------------------------------------
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // -------------------------------------------------------------------------
    // Apply point: the wrap from the last digit back to digit 0, or any clock
    // while disabled. When applying, the digit loaded on this very clock is
    // decoded from the shadow so the first digit of the new frame already
    // shows the new data.
    // -------------------------------------------------------------------------
    logic                frame_wrap;
    logic                apply;
    logic [4*DIGITS-1:0] src_value;
    logic [DIGITS-1:0]   src_dp;

    assign frame_wrap = (state_reg == SHOW) && scan_tick && (idx_reg == LAST_IDX);
    assign apply      = pending_reg && (!enable || frame_wrap);
    assign src_value  = apply ? shadow_reg    : disp_reg;
    assign src_dp     = apply ? shadow_dp_reg : disp_dp_reg;

    // -------------------------------------------------------------------------
    // Leading-zero blanking: digit gi is dark when every nibble from the most
    // significant one down to gi is zero. Digit 0 always shows.
    // -------------------------------------------------------------------------
    logic [DIGITS-1:0] lz_blank;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_lz
            if (gi == 0) begin : g_d0
                assign lz_blank[gi] = 1'b0;
            end else begin : g_dn
                assign lz_blank[gi] = blank_lz && (src_value[4*DIGITS-1:4*gi] == '0);
            end
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        if (!enable) begin
            state_next = SHOW;
            idx_next   = '0;
        end else begin
            case (state_reg)
                SHOW: begin
                    if (scan_tick) begin
                        state_next = BLANK;
                        idx_next   = (idx_reg == LAST_IDX) ? '0 : idx_reg + IDX_W'(1);
                    end
                end
                BLANK: begin
                    // Ticks landing in the blank slot are dropped.
                    state_next = SHOW;
                end
                default: begin
                    state_next = SHOW;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Output decode. seg/dp always describe the digit at idx_next, so entering
    // BLANK already presents the upcoming digit while the anodes are dark.
    // -------------------------------------------------------------------------
    logic [3:0] cur_nib;

    assign cur_nib = src_value[{idx_next, 2'b00} +: 4];

    always_comb begin
        an_next  = '1;
        seg_next = 7'b1111111;
        dp_next  = 1'b1;
        if (enable) begin
            seg_next = lz_blank[idx_next] ? 7'b1111111 : hex_to_seg(cur_nib);
            dp_next  = ~src_dp[idx_next];
            if (state_next == SHOW) begin
                an_next = ~(DIGITS'(1) << idx_next);
            end
        end
    end

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= SHOW;
            idx_reg       <= '0;
            shadow_reg    <= '0;
            shadow_dp_reg <= '0;
            pending_reg   <= 1'b0;
            disp_reg      <= '0;
            disp_dp_reg   <= '0;
            an_reg        <= '1;
            seg_reg       <= 7'b1111111;
            dp_reg        <= 1'b1;
            load_ack_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            idx_reg      <= idx_next;
            an_reg       <= an_next;
            seg_reg      <= seg_next;
            dp_reg       <= dp_next;
            load_ack_reg <= apply;

            if (apply) begin
                disp_reg    <= shadow_reg;
                disp_dp_reg <= shadow_dp_reg;
            end

            // A load coinciding with the apply point is captured after the
            // old shadow has been consumed and stays pending for next wrap.
            if (load) begin
                shadow_reg    <= value;
                shadow_dp_reg <= dp_in;
            end
            pending_reg <= load || (pending_reg && !apply);
        end
    end

    assign an       = an_reg;
    assign seg      = seg_reg;
    assign dp       = dp_reg;
    assign load_ack = load_ack_reg;

endmodule

// File: tb/tb_seven_seg_scan.sv
// -----------------------------------------------------------------------------
// tb_seven_seg_scan
//
// Self-checking bench for seven_seg_scan (DIGITS=4). A behavioural model of
// the display (which digit is lit, whether the slot is a blank, what value is
// on the display and what is waiting) predicts all outputs every clock.
// Directed scenarios walk the main behaviours, then a randomized phase runs.
// -----------------------------------------------------------------------------
module tb_seven_seg_scan;

    localparam int D = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           scan_tick;
    logic           enable;
    logic           load;
    logic [4*D-1:0] value;
    logic [D-1:0]   dp_in;
    logic           blank_lz;
    logic           load_ack;
    logic [D-1:0]   an;
    logic [6:0]     seg;
    logic           dp;

    always #5 clk = ~clk;

    seven_seg_scan #(.DIGITS(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .scan_tick (scan_tick),
        .enable    (enable),
        .load      (load),
        .value     (value),
        .dp_in     (dp_in),
        .blank_lz  (blank_lz),
        .load_ack  (load_ack),
        .an        (an),
        .seg       (seg),
        .dp        (dp)
    );

    int         checks   = 0;
    int         failures = 0;
    int         cycle    = 0;
    int         acks     = 0;
    logic [6:0] ack_seg  = '1;

    // ---------------- behavioural display model ----------------
    logic [6:0] glyph [16];
    int         m_digit   = 0;   // digit currently selected
    bit         m_blank   = 0;   // current slot is the ghosting blank
    int         m_disp    = 0;   // value on the display
    int         m_disp_dp = 0;
    int         m_next    = 0;   // value waiting for the frame wrap
    int         m_next_dp = 0;
    bit         m_waiting = 0;
    logic [D-1:0] e_an  = '1;
    logic [6:0]   e_seg = '1;
    logic         e_dp  = 1'b1;
    logic         e_ack = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", tag, cycle, got, exp);
        end
    endtask

    function automatic logic [7:0] face(input int digit);
        int         upper;
        logic [6:0] s;
        logic       d;
        upper = m_disp >> (4 * digit);
        s = (blank_lz && digit > 0 && upper == 0) ? 7'h7F : glyph[upper & 15];
        d = ((m_disp_dp >> digit) & 1) == 0;
        return {d, s};
    endfunction

    task automatic model_edge();
        bit wrap;
        if (!rst) begin
            m_digit = 0; m_blank = 0;
            m_disp = 0; m_disp_dp = 0; m_next = 0; m_next_dp = 0; m_waiting = 0;
            e_an = '1; e_seg = 7'h7F; e_dp = 1'b1; e_ack = 1'b0;
            return;
        end
        wrap  = enable && !m_blank && scan_tick && (m_digit == D - 1);
        e_ack = 1'b0;
        if (m_waiting && (!enable || wrap)) begin
            m_disp = m_next; m_disp_dp = m_next_dp; m_waiting = 0; e_ack = 1'b1;
        end
        if (load) begin
            m_next = int'(value); m_next_dp = int'(dp_in); m_waiting = 1;
        end
        if (!enable) begin
            m_digit = 0; m_blank = 0;
            e_an = '1; e_seg = 7'h7F; e_dp = 1'b1;
        end else begin
            if (m_blank) m_blank = 0;
            else if (scan_tick) begin
                m_digit = (m_digit + 1) % D;
                m_blank = 1;
            end
            {e_dp, e_seg} = face(m_digit);
            for (int i = 0; i < D; i++) e_an[i] = !(i == m_digit && !m_blank);
        end
    endtask

    // One clock: inputs already set, model follows the edge, outputs compared.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        cycle++;
        check_eq("outs", {19'd0, load_ack, dp, seg, an}, {19'd0, e_ack, e_dp, e_seg, e_an});
        if (load_ack === 1'b1) begin
            acks++;
            ack_seg = seg;
            $display("ack cycle=%0d an=%b seg=%b dp=%b", cycle, an, seg, dp);
        end
        load      = 1'b0;
        scan_tick = 1'b0;
    endtask

    task automatic ticks(input int n, input int spacing);
        for (int t = 0; t < n; t++) begin
            repeat (spacing - 1) step();
            scan_tick = 1'b1;
            step();
        end
    endtask

    // Advance until the last digit is being shown.
    task automatic goto_last();
        int budget = 16;
        while (!(m_digit == D - 1 && !m_blank) && budget > 0) begin
            scan_tick = 1'b1;
            step();
            step();
            budget--;
        end
        check_eq("goto_an", an, 4'b0111);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cycle);
        $fatal(1, "watchdog");
    end

    initial begin
        glyph[0]  = 7'b1000000; glyph[1]  = 7'b1111001; glyph[2]  = 7'b0100100; glyph[3]  = 7'b0110000;
        glyph[4]  = 7'b0011001; glyph[5]  = 7'b0010010; glyph[6]  = 7'b0000010; glyph[7]  = 7'b1111000;
        glyph[8]  = 7'b0000000; glyph[9]  = 7'b0010000; glyph[10] = 7'b0001000; glyph[11] = 7'b0000011;
        glyph[12] = 7'b1000110; glyph[13] = 7'b0100001; glyph[14] = 7'b0000110; glyph[15] = 7'b0001110;

        rst = 1'b0; enable = 1'b1; scan_tick = 1'b0; load = 1'b0;
        value = '0; dp_in = '0; blank_lz = 1'b0;

        // Reset, then the plain scan sequence
        repeat (3) step();
        check_eq("rst_an", an, 4'hF);
        check_eq("rst_seg", seg, 7'h7F);
        rst = 1'b1;
        step();
        check_eq("first_an", an, 4'b1110);
        check_eq("first_seg", seg, 7'b1000000);
        ticks(8, 16);
        step();
        $display("scan frame done cycle=%0d", cycle);

        // Load while digit 1 is shown; applied only at the wrap
        scan_tick = 1'b1; step(); step();
        acks = 0;
        load = 1'b1; value = 16'h1A3F; dp_in = 4'b0100;
        step();
        check_eq("l1_early", acks, 0);
        ticks(4, 4);
        check_eq("l1_acks", acks, 1);
        check_eq("l1_seg", ack_seg, 7'b0001110);
        ticks(4, 4);

        // Leading-zero blanking
        blank_lz = 1'b1;
        load = 1'b1; value = 16'h0042; dp_in = 4'b0000;
        step();
        ticks(8, 3);
        load = 1'b1; value = 16'h0000;
        step();
        ticks(8, 3);
        blank_lz = 1'b0;

        // Two loads before a wrap -> one ack with the later data
        acks = 0;
        load = 1'b1; value = 16'h1111; step();
        step();
        load = 1'b1; value = 16'h2222; step();
        ticks(4, 2);
        ticks(4, 2);
        check_eq("dbl_acks", acks, 1);
        check_eq("dbl_seg", ack_seg, 7'b0100100);

        // Load on the exact apply-point clock
        goto_last();
        acks = 0;
        load = 1'b1; value = 16'h4444; step();
        scan_tick = 1'b1; load = 1'b1; value = 16'h5555; step();
        check_eq("apl_ack1", acks, 1);
        check_eq("apl_seg1", ack_seg, 7'b0011001);
        ticks(4, 2);
        check_eq("apl_acks", acks, 2);
        check_eq("apl_seg2", ack_seg, 7'b0010010);

        // Drop enable with a load pending
        step();
        load = 1'b1; value = 16'h6666; step();
        enable = 1'b0; step();
        check_eq("dis_ack", load_ack, 1'b1);
        check_eq("dis_an", an, 4'hF);
        check_eq("dis_seg", seg, 7'h7F);
        scan_tick = 1'b1; step();
        step();
        enable = 1'b1; step();
        check_eq("reen_an", an, 4'b1110);
        ticks(3, 5);

        // Reset with a load pending
        load = 1'b1; value = 16'h7777; step();
        rst = 1'b0; step();
        check_eq("rstp_ack", load_ack, 1'b0);
        check_eq("rstp_an", an, 4'hF);
        check_eq("rstp_dp", dp, 1'b1);
        rst = 1'b1; step();
        check_eq("rstp_seg", seg, 7'b1000000);
        check_eq("rstp_an0", an, 4'b1110);

        // Randomized phase
        for (int i = 0; i < 4000; i++) begin
            rst       = ($urandom_range(0, 299) != 0);
            enable    = ($urandom_range(0, 39) != 0);
            scan_tick = (i % 1000 < 200) ? 1'b1 : ($urandom_range(0, 5) == 0);
            load      = ($urandom_range(0, 24) == 0);
            dp_in     = D'($urandom);
            if ($urandom_range(0, 49) == 0) blank_lz = ~blank_lz;
            case ($urandom_range(0, 4))
                0:       value = 16'($urandom);
                1:       value = 16'($urandom) & 16'h00FF;
                2:       value = 16'($urandom) & 16'h000F;
                3:       value = 16'($urandom) & 16'h0FFF;
                default: value = 16'h0000;
            endcase
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
